// File: rtl/axi_inf_write_state_core.sv
// rtl/axi_inf_write_state_core.sv - AXI4 single-burst write master fed from a FWFT stream FIFO
//
// Accepts one burst request at a time, issues AW, streams req_len+1 beats
// from the FIFO head onto W (wlast on the final beat), then collects B and
// reports completion.
//
// Ports:
//   axi_aclk, axi_resetn         clock, asynchronous active-low reset
//   write_req, req_len, req_addr request (sampled only while idle)
//   req_resp, req_done, req_err  one-cycle status pulses
//   pull_data, pull_data_valid   FWFT FIFO head word and not-empty flag
//   pull_data_en                 FIFO pop, asserted on each W handshake
//   axi_aw*, axi_w*, axi_b*      AXI4 write address, data and response channels
`timescale 1ns/1ps
module axi_inf_write_state_core #(
  parameter int IDSIZE = 3,
  parameter int ID     = 0,
  parameter int LSIZE  = 9,
  parameter int ASIZE  = 29,
  parameter int DSIZE  = 256
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic                 write_req,
  input  logic [LSIZE-1:0]     req_len,
  input  logic [ASIZE-1:0]     req_addr,
  output logic                 req_resp,
  output logic                 req_done,
  output logic                 req_err,
  input  logic [DSIZE-1:0]     pull_data,
  input  logic                 pull_data_valid,
  output logic                 pull_data_en,
  output logic [IDSIZE-1:0]    axi_awid,
  output logic [ASIZE-1:0]     axi_awaddr,
  output logic [LSIZE-1:0]     axi_awlen,
  output logic [2:0]           axi_awsize,
  output logic [1:0]           axi_awburst,
  output logic                 axi_awlock,
  output logic [3:0]           axi_awcache,
  output logic [2:0]           axi_awprot,
  output logic [3:0]           axi_awqos,
  output logic                 axi_awvalid,
  input  logic                 axi_awready,
  output logic [DSIZE-1:0]     axi_wdata,
  output logic [DSIZE/8-1:0]   axi_wstrb,
  output logic                 axi_wlast,
  output logic                 axi_wvalid,
  input  logic                 axi_wready,
  input  logic [IDSIZE-1:0]    axi_bid,
  input  logic [1:0]           axi_bresp,
  input  logic                 axi_bvalid,
  output logic                 axi_bready
);

  localparam logic [2:0]        AWSIZE = 3'($clog2(DSIZE / 8));
  localparam logic [IDSIZE-1:0] ID_V   = IDSIZE'(ID);

  typedef enum logic [1:0] {IDLE, AW, WDATA, WRESP} state_t;

  state_t           state, state_nxt;
  logic [LSIZE-1:0] cnt, cnt_nxt;
  logic [ASIZE-1:0] awaddr_nxt;
  logic [LSIZE-1:0] awlen_nxt;
  logic             awvalid_nxt, bready_nxt;
  logic             req_resp_nxt, req_done_nxt, req_err_nxt;
  logic             in_wdata;

  assign axi_awid    = ID_V;
  assign axi_awsize  = AWSIZE;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'b0011;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;
  assign axi_wstrb   = '1;

  // W channel is a straight pass-through of the FIFO head, gated by state so
  // that nothing leaks out of IDLE/AW/WRESP or during reset.
  assign in_wdata     = (state == WDATA);
  assign axi_wdata    = pull_data;
  assign axi_wvalid   = in_wdata && pull_data_valid;
  assign axi_wlast    = in_wdata && (cnt == axi_awlen);
  assign pull_data_en = axi_wvalid && axi_wready;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awvalid <= 1'b0;
      axi_bready  <= 1'b0;
      req_resp    <= 1'b0;
      req_done    <= 1'b0;
      req_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      axi_awaddr  <= awaddr_nxt;
      axi_awlen   <= awlen_nxt;
      axi_awvalid <= awvalid_nxt;
      axi_bready  <= bready_nxt;
      req_resp    <= req_resp_nxt;
      req_done    <= req_done_nxt;
      req_err     <= req_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    awaddr_nxt   = axi_awaddr;
    awlen_nxt    = axi_awlen;
    awvalid_nxt  = axi_awvalid;
    bready_nxt   = axi_bready;
    req_resp_nxt = 1'b0;
    req_done_nxt = 1'b0;
    req_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (write_req) begin
          state_nxt    = AW;
          awaddr_nxt   = req_addr;
          awlen_nxt    = req_len;
          awvalid_nxt  = 1'b1;
          req_resp_nxt = 1'b1;
        end
      end
      AW: begin
        if (axi_awready) begin
          state_nxt   = WDATA;
          awvalid_nxt = 1'b0;
          cnt_nxt     = '0;
        end
      end
      WDATA: begin
        // The last beat leaves the counter at len rather than incrementing,
        // so a full 2^LSIZE-beat burst never wraps it.
        if (pull_data_en) begin
          if (axi_wlast) begin
            state_nxt  = WRESP;
            bready_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + LSIZE'(1);
          end
        end
      end
      WRESP: begin
        if (axi_bvalid) begin
          state_nxt    = IDLE;
          bready_nxt   = 1'b0;
          req_done_nxt = 1'b1;
          req_err_nxt  = (axi_bresp != 2'b00) || (axi_bid != ID_V);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
